// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared encodings for the PC sequencer.
//   br_op_e : control-transfer kinds as decoded in ID (9-15 unused, act as none)
//   state_e : sequencer FSM states
//   RESET_PC_DEF / EXC_VEC_DEF : default boot and exception entry addresses
package pc_seq_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2,
    OP_BGTZ = 4'd3,
    OP_BLEZ = 4'd4,
    OP_BLTZ = 4'd5,
    OP_BGEZ = 4'd6,
    OP_J    = 4'd7,
    OP_JR   = 4'd8
  } br_op_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

endpackage

// File: rtl/pc_seq_br_cmp.sv
// br_cmp -- combinational branch condition evaluator.
//   rs_val, rt_val : forwarded operands, compared as signed CMP_W values
//   br_op          : transfer kind; j/jr are always taken, unknown ops never
//   taken          : condition holds (caller qualifies with br_valid)
module br_cmp
  import pc_seq_pkg::*;
#(
  parameter int CMP_W = 32
) (
  input  logic [CMP_W-1:0] rs_val,
  input  logic [CMP_W-1:0] rt_val,
  input  logic [3:0]       br_op,
  output logic             taken
);

  // Compares against zero reduce to sign bit / zero test.
  logic rs_neg, rs_zero;
  assign rs_neg  = rs_val[CMP_W-1];
  assign rs_zero = ~|rs_val;

  always_comb begin
    taken = 1'b0;
    case (br_op)
      OP_BEQ:  taken = (rs_val == rt_val);
      OP_BNE:  taken = (rs_val != rt_val);
      OP_BGTZ: taken = !rs_neg && !rs_zero;
      OP_BLEZ: taken = rs_neg || rs_zero;
      OP_BLTZ: taken = rs_neg;
      OP_BGEZ: taken = !rs_neg;
      OP_J,
      OP_JR:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_seq.sv
// pc_seq -- fetch PC sequencer with MIPS-style delay slot.
//   clk, reset(async, active-low)
//   stall                 : hold pc; a taken transfer is parked in a pending slot
//   br_valid/br_op/br_pc  : ID-stage transfer; imm26 gives jump index / offset
//   rs_val, rt_val        : forwarded operands for compare and jr target
//   exc_req, eret         : exception entry / return
//   pc, fetch_valid       : fetch address and its validity
//   link                  : br_pc+8 (combinational)
//   redirect              : next pc is not pc+4 (combinational, 0 while stalled)
//   epc, bd               : saved exception PC and delay-slot flag
// Optional feature: define PC_SEQ_EPC_EN for epc/bd capture and eret.
// Assumes ADDR_W > 28 and CMP_W >= ADDR_W.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                CMP_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(EXC_VEC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [3:0]        br_op,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [25:0]       imm26,
  input  logic [CMP_W-1:0]  rs_val,
  input  logic [CMP_W-1:0]  rt_val,
  input  logic              exc_req,
  input  logic              eret,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] link,
  output logic              redirect,
  output logic [ADDR_W-1:0] epc,
  output logic              bd
);

  state_e            state;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_t;
  logic              cmp_taken, taken, eret_en;
  logic [ADDR_W-1:0] pc_inc, br_seq, br_off, tgt, npc, epc_cur;

  br_cmp #(.CMP_W(CMP_W)) u_cmp (
    .rs_val (rs_val),
    .rt_val (rt_val),
    .br_op  (br_op),
    .taken  (cmp_taken)
  );

  assign taken  = br_valid && cmp_taken;
  assign pc_inc = pc + ADDR_W'(4);
  assign br_seq = br_pc + ADDR_W'(4);
  assign br_off = {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};
  assign link   = br_pc + ADDR_W'(8);

  always_comb begin
    tgt = br_seq + br_off;
    case (br_op)
      OP_J:    tgt = {br_seq[ADDR_W-1:28], imm26, 2'b00};
      OP_JR:   tgt = rs_val[ADDR_W-1:0];
      default: tgt = br_seq + br_off;
    endcase
  end

  // BOOT and TRAP always step sequentially; only RUN applies the priority chain.
  always_comb begin
    npc = pc_inc;
    if (state == ST_RUN) begin
      if (exc_req)     npc = EXC_VEC;
      else if (eret_en) npc = epc_cur;
      else if (stall)  npc = pc;
      else if (pend_v) npc = pend_t;
      else if (taken)  npc = tgt;
    end
  end

  assign redirect = !stall && (npc != pc_inc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      pend_v      <= 1'b0;
      pend_t      <= '0;
    end else begin
      pc <= npc;
      case (state)
        ST_BOOT: begin
          state       <= ST_RUN;
          fetch_valid <= 1'b1;
        end
        ST_TRAP: state <= ST_RUN;
        ST_RUN: begin
          if (exc_req) begin
            state  <= ST_TRAP;
            pend_v <= 1'b0;
          end else if (eret_en) begin
            // pending target survives an eret
          end else if (stall) begin
            // latest taken transfer wins the single pending slot
            if (taken) begin
              pend_v <= 1'b1;
              pend_t <= tgt;
            end
          end else if (pend_v) begin
            pend_v <= 1'b0;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

`ifdef PC_SEQ_EPC_EN
  logic [ADDR_W-1:0] epc_q;
  logic              bd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_q <= '0;
      bd_q  <= 1'b0;
    end else if (state == ST_RUN && exc_req) begin
      epc_q <= br_valid ? br_pc : pc;
      bd_q  <= br_valid;
    end
  end

  assign eret_en = eret;
  assign epc_cur = epc_q;
  assign epc     = epc_q;
  assign bd      = bd_q;
`else
  logic unused_eret;
  assign unused_eret = eret;
  assign eret_en     = 1'b0;
  assign epc_cur     = '0;
  assign epc         = '0;
  assign bd          = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
module tb_pc_seq;

  logic        clk, reset, stall, br_valid, exc_req, eret;
  logic [3:0]  br_op;
  logic [31:0] br_pc, rs_val, rt_val;
  logic [25:0] imm26;
  logic [31:0] pc, link, epc;
  logic        fetch_valid, redirect, bd;

`ifdef PC_SEQ_EPC_EN
  localparam bit EPC_ON = 1'b1;
`else
  localparam bit EPC_ON = 1'b0;
`endif

  pc_seq dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_op(br_op),
    .br_pc(br_pc), .imm26(imm26), .rs_val(rs_val), .rt_val(rt_val),
    .exc_req(exc_req), .eret(eret), .pc(pc), .fetch_valid(fetch_valid),
    .link(link), .redirect(redirect), .epc(epc), .bd(bd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference ----------------
  // mode: 0 = booting, 1 = running, 2 = exception entry cycle
  int          m_mode;
  logic [31:0] m_pc, m_pt, m_epc;
  bit          m_pv, m_bd;

  function automatic bit m_taken();
    if (!br_valid) return 1'b0;
    case (br_op)
      4'd1: return rs_val == rt_val;
      4'd2: return rs_val != rt_val;
      4'd3: return $signed(rs_val) > 0;
      4'd4: return $signed(rs_val) <= 0;
      4'd5: return $signed(rs_val) < 0;
      4'd6: return $signed(rs_val) >= 0;
      4'd7, 4'd8: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] seq;
    int          off;
    seq = br_pc + 32'd4;
    off = int'($signed(imm26[15:0]));
    if (br_op == 4'd7) return (seq & 32'hF000_0000) | {4'h0, imm26, 2'b00};
    if (br_op == 4'd8) return rs_val;
    return seq + 32'(off * 4);
  endfunction

  function automatic logic [31:0] m_next();
    if (m_mode != 1)     return m_pc + 32'd4;
    if (exc_req)         return 32'h0000_4180;
    if (EPC_ON && eret)  return m_epc;
    if (stall)           return m_pc;
    if (m_pv)            return m_pt;
    if (m_taken())       return m_target();
    return m_pc + 32'd4;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= 0; m_pc <= 32'h0000_3000; m_pv <= 1'b0; m_pt <= '0;
      m_epc <= '0; m_bd <= 1'b0;
    end else begin
      m_pc <= m_next();
      if (m_mode != 1) m_mode <= 1;
      else if (exc_req) begin
        m_mode <= 2; m_pv <= 1'b0;
        if (EPC_ON) begin
          m_epc <= br_valid ? br_pc : m_pc;
          m_bd  <= br_valid;
        end
      end else if (EPC_ON && eret) begin
      end else if (stall) begin
        if (m_taken()) begin m_pv <= 1'b1; m_pt <= m_target(); end
      end else if (m_pv) m_pv <= 1'b0;
    end
  end

  // compare every cycle while out of reset
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("pc",          pc,          m_pc);
      chk("fetch_valid", fetch_valid, 32'(m_mode != 0));
      chk("redirect",    redirect,    32'(!stall && (m_next() != m_pc + 32'd4)));
      chk("link",        link,        br_pc + 32'd8);
      chk("epc",         epc,         m_epc);
      chk("bd",          bd,          32'(m_bd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 0; br_valid = 0; br_op = 0; exc_req = 0; eret = 0;
  endtask

  initial begin
    clk = 0; reset = 0; br_pc = 0; imm26 = 0; rs_val = 0; rt_val = 0;
    clr();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("boot_pc", pc, 32'h3000);
    chk("boot_fv", fetch_valid, 0);
    step();
    @(negedge clk);
    chk("seq_pc1", pc, 32'h3004);
    chk("seq_fv1", fetch_valid, 1);

    // beq taken backwards to its own pc
    step();
    br_valid = 1; br_op = 4'd1; br_pc = 32'h3010; imm26 = 26'h000FFFF; rs_val = 5; rt_val = 5;
    @(negedge clk);
    chk("seq_pc2", pc, 32'h3008);
    chk("beq_redirect", redirect, 1);
    chk("beq_link", link, 32'h3018);
    step();
    rt_val = 6;
    @(negedge clk);
    chk("beq_target", pc, 32'h3010);
    chk("beq_nt_redirect", redirect, 0);

    // bltz taken while stalled; target parked until stall drops
    step();
    stall = 1; br_op = 4'd5; br_pc = 32'h3100; imm26 = 26'h10; rs_val = 32'h8000_0000;
    @(negedge clk);
    chk("stall_pc_a", pc, 32'h3014);
    step();
    br_valid = 0;
    @(negedge clk);
    chk("stall_pc_b", pc, 32'h3014);
    step();
    @(negedge clk);
    chk("stall_pc_c", pc, 32'h3014);
    step();
    stall = 0;
    @(negedge clk);
    chk("pend_hold_pc", pc, 32'h3014);
    chk("pend_redirect", redirect, 1);

    // exception with stall and a transfer in ID
    step();
    exc_req = 1; br_valid = 1; br_op = 4'd0; br_pc = 32'h3020; stall = 1;
    @(negedge clk);
    chk("pend_target", pc, 32'h3144);
    chk("exc_stall_redirect", redirect, 0);
    step();
    clr();
    @(negedge clk);
    chk("trap_pc", pc, 32'h4180);
    chk("trap_fv", fetch_valid, 1);
    chk("trap_epc", epc, EPC_ON ? 32'h3020 : 32'h0);
    chk("trap_bd", bd, 32'(EPC_ON));
    step();
    eret = 1;
    @(negedge clk);
    chk("post_trap_pc", pc, 32'h4184);

    // jal into the top of the address space, then wrap
    step();
    eret = 0; br_valid = 1; br_op = 4'd7; br_pc = 32'hF000_0000; imm26 = 26'h3FF_FFFF;
    @(negedge clk);
    chk("eret_pc", pc, EPC_ON ? 32'h3020 : 32'h4188);
    chk("jal_redirect", redirect, 1);
    step();
    br_valid = 0;
    @(negedge clk);
    chk("jal_target", pc, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    chk("wrap_pc", pc, 32'h0);

    // async reset in the middle of the exception cycle
    step();
    exc_req = 1;
    step();
    exc_req = 0;
    chk("trap2_pc", pc, 32'h4180);
    #1 reset = 0;
    #1;
    chk("async_rst_pc", pc, 32'h3000);
    chk("async_rst_fv", fetch_valid, 0);
    @(posedge clk);
    #1 reset = 1;

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      step();
      stall    = ($urandom_range(0, 99) < 30);
      br_valid = ($urandom_range(0, 1) == 1);
      br_op    = 4'($urandom_range(0, 15));
      br_pc    = $urandom;
      imm26    = 26'($urandom);
      exc_req  = ($urandom_range(0, 99) < 4);
      eret     = ($urandom_range(0, 99) < 6);
      rt_val   = $urandom;
      case ($urandom_range(0, 3))
        0: rs_val = 0;
        1: rs_val = rt_val;
        2: rs_val = 32'h8000_0000 | 32'($urandom_range(0, 3));
        default: rs_val = $urandom;
      endcase
    end
    step();
    clr();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 The block SHALL expose these parameters, one per line (name, default, meaning):
- ADDR_W, 32, PC width.
- CMP_W, 32, operand width for branch compare.
- RESET_PC, 32'h0000_3000, first fetch address.
- EXC_VEC, 32'h0000_4180, exception entry address.
REQ-002 The block SHALL expose these ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-low.
- stall, in, 1, hold PC.
- br_valid, in, 1, ID-stage control-transfer present.
- br_op, in, 4, transfer kind.
- br_pc, in, ADDR_W, PC of the ID-stage instruction.
- imm26, in, 26, instruction index field; [15:0] is the offset.
- rs_val, in, CMP_W, forwarded rs.
- rt_val, in, CMP_W, forwarded rt.
- exc_req, in, 1, take exception.
- eret, in, 1, return from exception.
- pc, out, ADDR_W, fetch address.
- fetch_valid, out, 1, pc is fetchable.
- link, out, ADDR_W, br_pc+8.
- redirect, out, 1, next pc is non-sequential.
- epc, out, ADDR_W, saved exception PC.
- bd, out, 1, exception victim was a delay slot.

Function
REQ-003 br_op encodings SHALL be: 0 none, 1 beq, 2 bne, 3 bgtz, 4 blez, 5 bltz, 6 bgez, 7 j/jal, 8 jr/jalr; 9-15 SHALL behave as none.
REQ-004 Compares SHALL be signed on CMP_W; beq and bne compare rs_val with rt_val; ops 3-6 compare rs_val with 0.
REQ-005 Branch target SHALL be br_pc+4+(sign-extended offset<<2), truncated to ADDR_W.
REQ-006 Jump target SHALL be {(br_pc+4)[ADDR_W-1:28], imm26, 2'b00}.
REQ-007 jr target SHALL be rs_val[ADDR_W-1:0].
REQ-008 The delay-slot architecture SHALL apply: the instruction fetched while the transfer is in ID always executes, and the redirect affects the next pc.
REQ-009 The FSM SHALL have the states BOOT, RUN and TRAP.
REQ-010 BOOT SHALL be entered on reset, holding pc=RESET_PC with fetch_valid=0, and SHALL move to RUN on the first clock edge.
REQ-011 TRAP SHALL hold pc=EXC_VEC with fetch_valid=1 for one cycle and then move to RUN.
REQ-012 In RUN, the next pc SHALL be chosen by this priority: exc_req enters TRAP; then eret loads epc; then stall holds pc; then a pending target; then a taken transfer; otherwise pc+4.
REQ-013 A taken transfer during stall SHALL latch its target into a one-entry pending register, applied on the first unstalled edge and then cleared.
REQ-014 A second taken transfer while an entry is pending SHALL overwrite that entry.
REQ-015 exc_req SHALL clear the pending entry.
REQ-016 pc+4 SHALL wrap modulo 2^ADDR_W.
REQ-017 redirect SHALL be combinational and high whenever the next pc differs from pc+4 and stall=0.
REQ-018 link SHALL be combinational.
REQ-019 exc_req and stall together SHALL take the exception, because exceptions override stall.

Reset
REQ-020 reset low SHALL asynchronously force state=BOOT, pc=RESET_PC, fetch_valid=0, pending cleared, epc=0 and bd=0.
REQ-021 reset deassertion SHALL be synchronised externally.
REQ-022 reset asserted mid-stall or mid-TRAP SHALL discard all in-flight state.

Configuration
REQ-023 Macro PC_SEQ_EPC_EN SHALL control exception-return support.
REQ-024 With PC_SEQ_EPC_EN defined, exc_req SHALL latch epc <= br_valid ? br_pc : pc and bd <= br_valid, and eret SHALL redirect to epc.
REQ-025 Without PC_SEQ_EPC_EN, epc and bd SHALL be tied to 0, eret SHALL be ignored, and the epc register SHALL be absent.

Structure
REQ-026 Package pc_seq_pkg SHALL hold the br_op encodings, the FSM state encoding, and the RESET_PC and EXC_VEC defaults.
REQ-027 Sub-module br_cmp SHALL be combinational, take rs_val, rt_val and br_op as inputs, and output taken; pc_seq SHALL instantiate it once.

Verification
REQ-028 Reset then release -> pc=0x3000 with fetch_valid=0 for one cycle, then 0x3004, then 0x3008.
REQ-029 beq, br_pc=0x3010, offset=0xFFFF, rs=rt=5 -> redirect=1, then pc=0x3010; with rs=5, rt=6 -> sequential pc.
REQ-030 bltz with rs=0x8000_0000 taken while stall=1 for 3 cycles -> pc holds for 3 cycles, then the target.
REQ-031 exc_req with br_valid=1, br_pc=0x3020 and stall=1 -> pc=0x4180 next; with PC_SEQ_EPC_EN, epc=0x3020 and bd=1; eret then gives pc=0x3020.
REQ-032 jal with br_pc=0xF000_0000 and imm26=0x3FF_FFFF -> pc=0xFFFF_FFFC, and a later pc+4 wraps to 0x0000_0000 (ADDR_W=32).
REQ-033 reset asserted asynchronously mid-TRAP -> pc=0x3000 immediately, without waiting for a clock edge.
